// File: rtl/fifo_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sum_pkg
//  Description : Shared types and constants for the column-sum sequencer:
//                sequencer FSM state encoding, fixed engine latency, data
//                width and in-flight counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_sum_pkg;

    // Byte width of pixels and of column sums.
    localparam int DATA_W  = 8;

    // Cycles from eng_flag to the matching po_flag.
    localparam int ENG_LAT = 3;

    // Width of the count of producing issues still inside the engine.
    localparam int INF_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

endpackage : fifo_sum_pkg
`default_nettype wire

// File: rtl/sum_result_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sum_result_buf
//  Description : Synchronous first-word-fall-through FIFO holding engine
//                results until the sink accepts them.
//  Ports       : clk_i/rst_i   clock, synchronous active-high reset
//                push_i/data_i write strobe and data
//                pop_i         read strobe (ignored when empty)
//                data_o        head entry (0 when empty)
//                empty_o/full_o/count_o  occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_result_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic w_do_push;
    logic w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    // When full, a simultaneous pop frees the slot being written.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    assign count_o = count_q;
    // Head is masked so the output reads 0 whenever nothing is stored.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : sum_result_buf
`default_nettype wire

// File: rtl/fifo_sum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sum_seq
//  Description : Sequencer in front of the 3-row column-sum engine. Accepts
//                a frame of ROWS*COLS bytes from a valid/ready source, issues
//                them to the engine as spaced single-cycle pulses, tracks
//                row/col position and in-flight results, and buffers engine
//                results for a valid/ready sink. Flags frame end and errors.
//  Ports       : sys_clk/sys_rst           clock, sync active-high reset
//                start                     begin a frame (IDLE only)
//                in_valid/in_data/in_ready byte source handshake
//                eng_flag/eng_data         to engine pi_flag/pi_data
//                eng_po_flag/eng_po_sum    from engine po_flag/po_sum
//                out_valid/out_data/out_ready  result sink handshake
//                busy/frame_done/frame_err frame status
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sum_seq
    import fifo_sum_pkg::*;
#(
    parameter int COLS      = 4,
    parameter int ROWS      = 5,
    parameter int GAP       = 3,
    parameter int RES_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              eng_flag,
    output logic [DATA_W-1:0] eng_data,
    input  logic              eng_po_flag,
    input  logic [DATA_W-1:0] eng_po_sum,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = $clog2(ROWS + 1);
    localparam int NRES   = (ROWS - 2) * COLS;
    localparam int RCNT_W = $clog2(ROWS * COLS + 1);
    localparam int HOLD_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam int DRN_W  = $clog2(ENG_LAT + 1);
    localparam int CNT_W  = $clog2(RES_DEPTH) + 1;
    localparam int OCC_W  = CNT_W + 1;

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              last_q;
    logic [HOLD_W-1:0] hold_q;
    logic [DRN_W-1:0]  drain_q;
    logic [INF_W-1:0]  inflight_q;
    logic [RCNT_W-1:0] res_cnt_q;
    logic [DATA_W-1:0] eng_data_q;
    logic              err_q;

    logic              w_start_acc;
    logic              w_producing;
    logic [OCC_W-1:0]  w_occ;
    logic              w_credit;
    logic              w_accept;
    logic              w_issue;
    logic              w_inc;
    logic              w_ret;
    logic              w_spurious;
    logic              w_last_pix;
    logic              w_hold_end;
    logic              w_drain_end;
    logic              w_cnt_err;
    logic              w_pop;
    logic              w_drop;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_buf_empty;
    logic              w_buf_full;
    logic [CNT_W-1:0]  w_buf_count;

    // ------------------------------------------------------------------
    // Position, credit and engine bookkeeping
    // ------------------------------------------------------------------
    assign w_start_acc = (state_q == ST_IDLE) & start;
    assign w_issue     = (state_q == ST_ISSUE);
    // Only pixels in the third row onward complete a 3-row column sum.
    assign w_producing = (row_q >= ROW_W'(2));
    assign w_last_pix  = (row_q == ROW_W'(ROWS - 1)) & (col_q == COL_W'(COLS - 1));

    // A producing pixel may only be issued if its result is guaranteed a
    // buffer slot, counting results already on their way back.
    assign w_occ    = OCC_W'(w_buf_count) + OCC_W'(inflight_q);
    assign w_credit = ~w_producing | (w_occ < OCC_W'(RES_DEPTH));
    assign w_accept = in_valid & in_ready;

    assign w_inc      = w_issue & w_producing;
    assign w_ret      = eng_po_flag & (inflight_q != '0);
    assign w_spurious = eng_po_flag & (inflight_q == '0);

    assign w_hold_end  = (hold_q == HOLD_W'(GAP - 2));
    assign w_drain_end = (state_q == ST_DRAIN) & (inflight_q == '0) &
                         (drain_q == DRN_W'(ENG_LAT - 1));
    assign w_cnt_err   = w_drain_end & (res_cnt_q != RCNT_W'(NRES));

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    assign w_pop  = out_valid & out_ready;
    // Spurious returns are never stored; valid returns are lost only when
    // the buffer is full and not being drained this cycle.
    assign w_drop = w_ret & w_buf_full & ~w_pop;

    sum_result_buf #(
        .DEPTH (RES_DEPTH),
        .W     (DATA_W)
    ) u_res_buf (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (w_ret),
        .data_i  (eng_po_sum),
        .pop_i   (w_pop),
        .data_o  (w_buf_data),
        .empty_o (w_buf_empty),
        .full_o  (w_buf_full),
        .count_o (w_buf_count)
    );

    assign out_valid = ~w_buf_empty;
    assign out_data  = w_buf_data;
    assign eng_data  = eng_data_q;
    assign frame_err = err_q;

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        eng_flag   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy     = 1'b1;
                in_ready = w_credit;
                if (in_valid && w_credit) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy     = 1'b1;
                eng_flag = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (w_hold_end) begin
                    state_d = last_q ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            last_q     <= 1'b0;
            hold_q     <= '0;
            drain_q    <= '0;
            inflight_q <= '0;
            res_cnt_q  <= '0;
            eng_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (w_start_acc) begin
                col_q  <= '0;
                row_q  <= '0;
                last_q <= 1'b0;
            end else if (w_issue) begin
                if (col_q == COL_W'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                if (w_last_pix) begin
                    last_q <= 1'b1;
                end
            end

            // Held until the next accept so the engine samples a stable byte.
            if (w_accept) begin
                eng_data_q <= in_data;
            end

            if (w_issue) begin
                hold_q <= '0;
            end else if (state_q == ST_HOLD) begin
                hold_q <= hold_q + 1'b1;
            end

            if (state_q != ST_DRAIN) begin
                drain_q <= '0;
            end else if (inflight_q == '0) begin
                drain_q <= drain_q + 1'b1;
            end

            case ({w_inc, w_ret})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            if (w_start_acc) begin
                res_cnt_q <= '0;
            end else if (w_ret) begin
                res_cnt_q <= res_cnt_q + 1'b1;
            end

            // An error event in the same cycle as start still wins.
            if (w_spurious || w_drop || w_cnt_err) begin
                err_q <= 1'b1;
            end else if (w_start_acc) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule : fifo_sum_seq
`default_nettype wire
